// File: rtl/quad_pkg.sv
// Shared constants, FSM encoding and frame byte selection for quad_uart_reporter.
package quad_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Byte idx of the packet: sync, count MSB..LSB, XOR checksum.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] snap);
    logic [7:0] sel;
    sel = SYNC_BYTE;
    case (idx)
      3'd0:    sel = SYNC_BYTE;
      3'd1:    sel = snap[31:24];
      3'd2:    sel = snap[23:16];
      3'd3:    sel = snap[15:8];
      3'd4:    sel = snap[7:0];
      3'd5:    sel = snap[31:24] ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
      default: sel = SYNC_BYTE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter.
// Ports: clk, rst_n (async active-low), start/data (load a byte), tx (serial out,
// idle high), done (pulse in the last cycle of the stop bit).
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic              active_q, active_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [9:0]        shreg_q, shreg_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign done      = active_q && baud_last && (bit_q == 4'd9);
  // Idle level comes from active_q, so reset forces tx high without a clock.
  assign tx        = active_q ? shreg_q[0] : 1'b1;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    // A start in the done cycle reloads directly, keeping bytes gapless.
    if (start && (!active_q || done)) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shreg_d  = {1'b1, data, 1'b0};
    end else if (active_q) begin
      if (baud_last) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shreg_d = {1'b1, shreg_q[9:1]};
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

endmodule

// File: rtl/quad_uart_reporter.sv
// Periodically snapshots the quadrature position count and sends it as a
// 6-byte packet (A5, count MSB..LSB, XOR checksum) over an 8N1 UART.
// Ports: clk, rst_n (async active-low), count (position), enable (reporting on),
// tx (serial out), busy (frame on the line), frame_drop (skipped-tick pulse).
module quad_uart_reporter
  import quad_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned REPORT_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] count,
  input  logic        enable,
  output logic        tx,
  output logic        busy,
  output logic        frame_drop
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned TICK_DIV     = CLK_HZ / REPORT_HZ;
  localparam int unsigned TIMER_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0]  LAST_IDX     = 3'(FRAME_BYTES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [31:0]        snap_q, snap_d;
  logic               drop_q, drop_d;
  logic               tick;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;

  assign tick       = enable && (timer_q == TIMER_W'(TICK_DIV - 1));
  assign busy       = (state_q != ST_IDLE);
  assign frame_drop = drop_q;

  always_comb begin
    timer_d  = '0;
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    drop_d   = tick && (state_q != ST_IDLE);
    tx_start = 1'b0;
    tx_data  = SYNC_BYTE;

    if (enable && !tick) begin
      timer_d = timer_q + 1'b1;
    end

    // The LOAD step is folded into the tick cycle and the done cycle of the
    // previous byte so the start bit and each following byte begin without a
    // gap; ST_LOAD only performs the same load if it is ever entered.
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (tick) begin
          snap_d   = count;
          tx_start = 1'b1;
          tx_data  = frame_byte(3'd0, count);
          state_d  = ST_SEND;
        end
      end
      ST_LOAD: begin
        tx_start = 1'b1;
        tx_data  = frame_byte(idx_q, snap_q);
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done) begin
          if (idx_q < LAST_IDX) begin
            idx_d    = idx_q + 3'd1;
            tx_start = 1'b1;
            tx_data  = frame_byte(idx_q + 3'd1, snap_q);
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      drop_q  <= drop_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx),
    .done (tx_done)
  );

endmodule

// File: tb/tb_quad_uart_reporter.sv
module tb_quad_uart_reporter;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [31:0] count;
  logic        tx, busy, frame_drop;
  logic        rst_n5, enable5;
  logic [31:0] count5;
  logic        tx5, busy5, frame_drop5;

  always #5 clk = ~clk;

  quad_uart_reporter #(.CLK_HZ(1000), .BAUD(100), .REPORT_HZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .count(count), .enable(enable),
    .tx(tx), .busy(busy), .frame_drop(frame_drop)
  );

  quad_uart_reporter #(.CLK_HZ(1000), .BAUD(100), .REPORT_HZ(5)) dut5 (
    .clk(clk), .rst_n(rst_n5), .count(count5), .enable(enable5),
    .tx(tx5), .busy(busy5), .frame_drop(frame_drop5)
  );

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  int          rel = 0, rel5 = 0;
  bit          sel = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  int          chg_at = -1;
  logic [31:0] chg_val = '0;
  int          drops[$];

  always @(negedge clk) if (rst_n5 && frame_drop5) drops.push_back(gcyc - rel5);

  function automatic int cur();
    return sel ? (gcyc - rel5) : (gcyc - rel);
  endfunction

  function automatic logic tx_now();
    return sel ? tx5 : tx;
  endfunction

  task automatic step();
    @(negedge clk);
    if (!sel && chg_at >= 0 && cur() == chg_at) count = chg_val;
  endtask

  task automatic wait_until(input int c);
    while (cur() < c) step();
  endtask

  task automatic release_rst();
    if (sel) begin rst_n5 = 1'b1; rel5 = gcyc; end
    else     begin rst_n  = 1'b1; rel  = gcyc; end
  endtask

  task automatic find_fall(input int limit, output int at);
    at = -1;
    while (cur() <= limit) begin
      if (tx_now() === 1'b0) begin
        at = cur();
        break;
      end
      step();
    end
  endtask

  task automatic decode_frame(input int s, output logic [47:0] got, output bit fr_ok);
    logic v;
    fr_ok = 1'b1;
    got   = '0;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 10; j++) begin
        wait_until(s + b * 100 + j * 10 + 5);
        v = tx_now();
        if (j == 0) begin
          if (v !== 1'b0) fr_ok = 1'b0;
        end else if (j == 9) begin
          if (v !== 1'b1) fr_ok = 1'b0;
        end else begin
          got[39 - 8 * b + j] = v;
        end
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0; rst_n5 = 1'b0;
    enable = 1'b1; enable5 = 1'b1;
    count = 32'h12345678; count5 = 32'h01020304;
    repeat (3) step();
    n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (frame_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop got=%b exp=0", frame_drop); end
    n_cmp++; if (tx5 !== 1'b1)         begin n_bad++; $display("FAIL reset_tx5 got=%b exp=1", tx5); end
    n_cmp++; if (busy5 !== 1'b0)       begin n_bad++; $display("FAIL reset_busy5 got=%b exp=0", busy5); end
    n_cmp++; if (frame_drop5 !== 1'b0) begin n_bad++; $display("FAIL reset_drop5 got=%b exp=0", frame_drop5); end
  endtask

  task automatic test_basic_frame();
    int          at;
    logic [47:0] got;
    bit          ok;
    sel = 1'b0;
    chg_at = 1200; chg_val = 32'h00000001;
    release_rst();
    wait_until(999);
    n_cmp++; if ({busy, tx} !== 2'b01) begin n_bad++; $display("FAIL pre_tick busy/tx got=%b exp=01", {busy, tx}); end
    find_fall(1100, at);
    n_cmp++; if (at != 1000) begin n_bad++; $display("FAIL first_fall got=%0d exp=1000", at); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_rise got=%b exp=1", busy); end
    decode_frame(1000, got, ok);
    n_cmp++; if (got !== 48'hA5_12345678_08) begin n_bad++; $display("FAIL frame1_bytes got=%h exp=a51234567808", got); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL frame1_framing got=%b exp=1", ok); end
    wait_until(1599);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_last got=%b exp=1", busy); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall got=%b exp=0", busy); end
    find_fall(2100, at);
    n_cmp++; if (at != 2000) begin n_bad++; $display("FAIL second_fall got=%0d exp=2000", at); end
    decode_frame(2000, got, ok);
    n_cmp++; if (got !== 48'hA5_00000001_01) begin n_bad++; $display("FAIL frame2_bytes got=%h exp=a50000000101", got); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL frame2_framing got=%b exp=1", ok); end
    chg_at = -1;
  endtask

  task automatic test_all_ones();
    int          at;
    logic [47:0] got;
    bit          ok;
    sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    count = 32'hFFFFFFFF;
    release_rst();
    find_fall(1100, at);
    n_cmp++; if (at != 1000) begin n_bad++; $display("FAIL ones_fall got=%0d exp=1000", at); end
    decode_frame(1000, got, ok);
    n_cmp++; if (got !== 48'hA5_FFFFFFFF_00) begin n_bad++; $display("FAIL ones_bytes got=%h exp=a5ffffffff00", got); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ones_framing got=%b exp=1", ok); end
    find_fall(2100, at);
    n_cmp++; if (at != 2000) begin n_bad++; $display("FAIL ones_period got=%0d exp=2000", at); end
  endtask

  task automatic test_drop();
    int          at;
    logic [47:0] got;
    bit          ok;
    rst_n = 1'b0;
    sel = 1'b1;
    drops.delete();
    release_rst();
    find_fall(300, at);
    n_cmp++; if (at != 200) begin n_bad++; $display("FAIL drop_first_fall got=%0d exp=200", at); end
    decode_frame(200, got, ok);
    n_cmp++; if (got !== 48'hA5_01020304_04) begin n_bad++; $display("FAIL drop_bytes got=%h exp=a50102030404", got); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL drop_framing got=%b exp=1", ok); end
    wait_until(799);
    n_cmp++; if (busy5 !== 1'b1) begin n_bad++; $display("FAIL drop_busy_last got=%b exp=1", busy5); end
    step();
    n_cmp++; if (busy5 !== 1'b0) begin n_bad++; $display("FAIL drop_busy_fall got=%b exp=0", busy5); end
    find_fall(1100, at);
    n_cmp++; if (at != 1000) begin n_bad++; $display("FAIL drop_next_fall got=%0d exp=1000", at); end
    n_cmp++; if (drops.size() != 3) begin n_bad++; $display("FAIL drop_count got=%0d exp=3", drops.size()); end
    else begin
      n_cmp++; if (drops[0] != 400) begin n_bad++; $display("FAIL drop0_cycle got=%0d exp=400", drops[0]); end
      n_cmp++; if (drops[1] != 600) begin n_bad++; $display("FAIL drop1_cycle got=%0d exp=600", drops[1]); end
      n_cmp++; if (drops[2] != 800) begin n_bad++; $display("FAIL drop2_cycle got=%0d exp=800", drops[2]); end
    end
    rst_n5 = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_enable_drop();
    int at;
    bit stray;
    sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    count = 32'h12345678;
    enable = 1'b1;
    release_rst();
    find_fall(1100, at);
    n_cmp++; if (at != 1000) begin n_bad++; $display("FAIL en_fall got=%0d exp=1000", at); end
    wait_until(1300);
    enable = 1'b0;
    wait_until(1599);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL en_busy_last got=%b exp=1", busy); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_busy_fall got=%b exp=0", busy); end
    stray = 1'b0;
    while (cur() < 3000) begin
      if (tx !== 1'b1 || busy !== 1'b0) stray = 1'b1;
      step();
    end
    n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL en_quiet got=%b exp=0", stray); end
    enable = 1'b1;
    find_fall(4100, at);
    n_cmp++; if (at != 4000) begin n_bad++; $display("FAIL en_resume_fall got=%0d exp=4000", at); end
  endtask

  task automatic test_async_reset();
    int          at;
    logic [47:0] got;
    bit          ok;
    sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    count = 32'h12345678;
    enable = 1'b1;
    release_rst();
    find_fall(1100, at);
    n_cmp++; if (at != 1000) begin n_bad++; $display("FAIL ar_fall got=%0d exp=1000", at); end
    wait_until(1300);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL ar_mid_start_bit got=%b exp=0", tx); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL ar_tx got=%b exp=1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
    count = 32'hA1B2C3D4;
    wait_until(1310);
    release_rst();
    find_fall(1100, at);
    n_cmp++; if (at != 1000) begin n_bad++; $display("FAIL ar_restart_fall got=%0d exp=1000", at); end
    decode_frame(1000, got, ok);
    n_cmp++; if (got !== 48'hA5_A1B2C3D4_04) begin n_bad++; $display("FAIL ar_bytes got=%h exp=a5a1b2c3d404", got); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ar_framing got=%b exp=1", ok); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_all_ones();
    test_drop();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
